axi_txn_monitor: RTL and testbench

Passive, synthesizable AXI4 snoop block that attaches to one master port, e.g. the serv0 port of dual_riscv_axi_system, downstream of the master's handshakes. It counts and classifies transactions in hardware:
- Reads split into instruction fetch vs data load by address threshold.
- Writes and write beats counted.
- Error responses and protocol violations flagged.
- Worst-case read latency measured.

Counters are exposed through a mux readout so benches and on-chip debug get the same statistics without hierarchical peeking. The block never drives any AXI signal.

---
 rtl/axi_txn_monitor.sv | 189 ++++++++++++++++++
 tb/tb_axi_txn_monitor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_txn_monitor.sv
// Passive AXI4 transaction monitor: classifies and counts handshakes on one
// master port, tracks in-flight reads/writes, flags error responses and
// protocol violations, and measures worst-case read latency.
module axi_txn_monitor #(
    parameter int unsigned              ADDR_WIDTH      = 32,
    parameter int unsigned              CNT_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0]    CODE_LIMIT      = 32'h0000_0100,
    parameter int unsigned              MAX_OUTSTANDING = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  mon_arvalid,
    input  logic                  mon_arready,
    input  logic [ADDR_WIDTH-1:0] mon_araddr,
    input  logic                  mon_rvalid,
    input  logic                  mon_rready,
    input  logic                  mon_rlast,
    input  logic [1:0]            mon_rresp,
    input  logic                  mon_awvalid,
    input  logic                  mon_awready,
    input  logic                  mon_wvalid,
    input  logic                  mon_wready,
    input  logic                  mon_wlast,
    input  logic                  mon_bvalid,
    input  logic                  mon_bready,
    input  logic [1:0]            mon_bresp,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [2:0]            rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [2:0]            rd_outstanding,
    output logic [2:0]            wr_outstanding,
    output logic                  resp_err,
    output logic                  proto_err
);

    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_MEAS   = 1'b1;
    localparam logic [3:0]        MAX_OS   = 4'(MAX_OUTSTANDING);
    localparam logic signed [7:0] MAX_DIFF = 8'(MAX_OUTSTANDING);

    logic ar_hs, r_hs, r_done, aw_hs, w_hs, wl_hs, b_hs, r_err, b_err, is_code;

    logic [CNT_WIDTH-1:0] inst_q, inst_d, data_q, data_d, wr_q, wr_d;
    logic [CNT_WIDTH-1:0] wbeat_q, wbeat_d, err_q, err_d;
    logic [CNT_WIDTH-1:0] maxlat_q, maxlat_d, lat_q, lat_d, rd_data_q, rd_data_d;
    logic [CNT_WIDTH:0]   rd_sum;
    logic [2:0]           rdos_q, rdos_d, wros_q, wros_d;
    logic signed [7:0]    wdiff_q, wdiff_d;
    logic                 resp_q, resp_d, proto_q, proto_d;
    logic [0:0]           state_q, state_d;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(inc);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign ar_hs   = mon_arvalid & mon_arready;
    assign r_hs    = mon_rvalid & mon_rready;
    assign r_done  = r_hs & mon_rlast;
    assign aw_hs   = mon_awvalid & mon_awready;
    assign w_hs    = mon_wvalid & mon_wready;
    assign wl_hs   = w_hs & mon_wlast;
    assign b_hs    = mon_bvalid & mon_bready;
    assign r_err   = r_hs & (mon_rresp != 2'b00);
    assign b_err   = b_hs & (mon_bresp != 2'b00);
    assign is_code = mon_araddr < CODE_LIMIT;
    assign rd_sum  = {1'b0, inst_q} + {1'b0, data_q};

    // Statistics counters (gated by enable) and registered readout mux
    always_comb begin
        inst_d  = inst_q;
        data_d  = data_q;
        wr_d    = wr_q;
        wbeat_d = wbeat_q;
        err_d   = err_q;
        if (enable) begin
            if (ar_hs && is_code)  inst_d = sat_add(inst_q, 2'd1);
            if (ar_hs && !is_code) data_d = sat_add(data_q, 2'd1);
            if (aw_hs)             wr_d   = sat_add(wr_q, 2'd1);
            if (w_hs)              wbeat_d = sat_add(wbeat_q, 2'd1);
            err_d = sat_add(err_q, {1'b0, r_err} + {1'b0, b_err});
        end
        case (rd_sel)
            3'd0:    rd_data_d = inst_q;
            3'd1:    rd_data_d = data_q;
            3'd2:    rd_data_d = wr_q;
            3'd3:    rd_data_d = wbeat_q;
            3'd4:    rd_data_d = err_q;
            3'd5:    rd_data_d = maxlat_q;
            3'd6:    rd_data_d = rd_sum[CNT_WIDTH] ? '1 : rd_sum[CNT_WIDTH-1:0];
            default: rd_data_d = CNT_WIDTH'({proto_q, resp_q});
        endcase
    end

    // Outstanding tracking and sticky error flags (independent of enable)
    always_comb begin
        rdos_d  = rdos_q;
        wros_d  = wros_q;
        wdiff_d = wdiff_q;
        resp_d  = resp_q | r_err | b_err;
        proto_d = proto_q;
        if (ar_hs && !r_done) begin
            if (({1'b0, rdos_q} + 4'd1) > MAX_OS) proto_d = 1'b1;
            if (rdos_q != 3'd7) rdos_d = rdos_q + 3'd1;
        end else if (r_done && !ar_hs) begin
            if (rdos_q == 3'd0) proto_d = 1'b1;
            else                rdos_d  = rdos_q - 3'd1;
        end
        if (aw_hs && !b_hs) begin
            if (({1'b0, wros_q} + 4'd1) > MAX_OS) proto_d = 1'b1;
            if (wros_q != 3'd7) wros_d = wros_q + 3'd1;
        end else if (b_hs && !aw_hs) begin
            if (wros_q == 3'd0) proto_d = 1'b1;
            else                wros_d  = wros_q - 3'd1;
        end
        // Running (wlast beats - AW accepts), clamped to the signed 8-bit range
        if (wl_hs && !aw_hs && wdiff_q != 8'sh7F) wdiff_d = wdiff_q + 8'sd1;
        if (aw_hs && !wl_hs && wdiff_q != 8'sh80) wdiff_d = wdiff_q - 8'sd1;
        if (wdiff_d > MAX_DIFF) proto_d = 1'b1;
    end

    // Read latency FSM: measures only reads started with nothing in flight
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        maxlat_d = maxlat_q;
        case (state_q)
            S_IDLE: begin
                if (ar_hs && rdos_q == 3'd0) begin
                    state_d = S_MEAS;
                    lat_d   = CNT_WIDTH'(1);
                end
            end
            default: begin
                if (r_done) begin
                    state_d = S_IDLE;
                    if (enable && lat_q > maxlat_q) maxlat_d = lat_q;
                end else if (lat_q != '1) begin
                    lat_d = lat_q + CNT_WIDTH'(1);
                end
            end
        endcase
    end

    // State registers; clear behaves like reset but keeps the readout live
    always_ff @(posedge ACLK) begin
        if (ARESET || clear) begin
            inst_q   <= '0;
            data_q   <= '0;
            wr_q     <= '0;
            wbeat_q  <= '0;
            err_q    <= '0;
            maxlat_q <= '0;
            lat_q    <= '0;
            rdos_q   <= '0;
            wros_q   <= '0;
            wdiff_q  <= '0;
            resp_q   <= 1'b0;
            proto_q  <= 1'b0;
            state_q  <= S_IDLE;
            rd_data_q <= ARESET ? '0 : rd_data_d;
        end else begin
            inst_q    <= inst_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            wbeat_q   <= wbeat_d;
            err_q     <= err_d;
            maxlat_q  <= maxlat_d;
            lat_q     <= lat_d;
            rdos_q    <= rdos_d;
            wros_q    <= wros_d;
            wdiff_q   <= wdiff_d;
            resp_q    <= resp_d;
            proto_q   <= proto_d;
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data        = rd_data_q;
    assign rd_outstanding = rdos_q;
    assign wr_outstanding = wros_q;
    assign resp_err       = resp_q;
    assign proto_err      = proto_q;

endmodule

// File: tb/tb_axi_txn_monitor.sv
// Testbench for axi_txn_monitor: directed scenarios plus randomized traffic,
// every cycle checked against a transaction-level reference model.
module tb_axi_txn_monitor;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MAXO = 4;
    localparam int CODE = 'h100;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        mon_arvalid = 1'b0, mon_arready = 1'b0;
    logic [31:0] mon_araddr = '0;
    logic        mon_rvalid = 1'b0, mon_rready = 1'b0, mon_rlast = 1'b0;
    logic [1:0]  mon_rresp = '0;
    logic        mon_awvalid = 1'b0, mon_awready = 1'b0;
    logic        mon_wvalid = 1'b0, mon_wready = 1'b0, mon_wlast = 1'b0;
    logic        mon_bvalid = 1'b0, mon_bready = 1'b0;
    logic [1:0]  mon_bresp = '0;
    logic        clear = 1'b0, enable = 1'b1;
    logic [2:0]  rd_sel = '0;
    logic [CW-1:0] rd_data;
    logic [2:0]  rd_outstanding, wr_outstanding;
    logic        resp_err, proto_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: unbounded event counts, saturated on readout
    int m_inst, m_data, m_wr, m_wbeat, m_err, m_max;
    int m_rd, m_wo, m_diff, m_start, cyc;
    bit m_resp, m_proto, m_meas;

    axi_txn_monitor #(.CNT_WIDTH(CW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .mon_arvalid(mon_arvalid), .mon_arready(mon_arready), .mon_araddr(mon_araddr),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
        .mon_rresp(mon_rresp),
        .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
        .mon_wvalid(mon_wvalid), .mon_wready(mon_wready), .mon_wlast(mon_wlast),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready), .mon_bresp(mon_bresp),
        .clear(clear), .enable(enable), .rd_sel(rd_sel), .rd_data(rd_data),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .resp_err(resp_err), .proto_err(proto_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic int sel_val(input int s);
        case (s)
            0: return sat(m_inst);
            1: return sat(m_data);
            2: return sat(m_wr);
            3: return sat(m_wbeat);
            4: return sat(m_err);
            5: return m_max;
            6: return sat(m_inst + m_data);
            default: return (m_proto ? 2 : 0) + (m_resp ? 1 : 0);
        endcase
    endfunction

    task automatic model_zero();
        m_inst = 0; m_data = 0; m_wr = 0; m_wbeat = 0; m_err = 0; m_max = 0;
        m_rd = 0; m_wo = 0; m_diff = 0; m_resp = 0; m_proto = 0; m_meas = 0;
    endtask

    task automatic model_step();
        bit ar, rd, aw, wb, wl, b, re, be;
        ar = mon_arvalid && mon_arready;
        rd = mon_rvalid && mon_rready && mon_rlast;
        aw = mon_awvalid && mon_awready;
        wb = mon_wvalid && mon_wready;
        wl = wb && mon_wlast;
        b  = mon_bvalid && mon_bready;
        re = mon_rvalid && mon_rready && (mon_rresp != 0);
        be = b && (mon_bresp != 0);
        if (ARESET || clear) begin
            model_zero();
            return;
        end
        if (enable) begin
            if (ar && int'(mon_araddr) >= 0 && mon_araddr < CODE) m_inst++;
            else if (ar) m_data++;
            if (aw) m_wr++;
            if (wb) m_wbeat++;
            m_err += int'(re) + int'(be);
        end
        if (re || be) m_resp = 1;
        if (m_meas) begin
            if (rd) begin
                if (enable && sat(cyc - m_start) > m_max) m_max = sat(cyc - m_start);
                m_meas = 0;
            end
        end else if (ar && m_rd == 0) begin
            m_meas = 1;
            m_start = cyc;
        end
        if (ar && !rd) begin
            if (m_rd + 1 > MAXO) m_proto = 1;
            if (m_rd < 7) m_rd++;
        end else if (rd && !ar) begin
            if (m_rd == 0) m_proto = 1; else m_rd--;
        end
        if (aw && !b) begin
            if (m_wo + 1 > MAXO) m_proto = 1;
            if (m_wo < 7) m_wo++;
        end else if (b && !aw) begin
            if (m_wo == 0) m_proto = 1; else m_wo--;
        end
        m_diff += int'(wl) - int'(aw);
        if (m_diff > MAXO) m_proto = 1;
    endtask

    // one clock: predict, advance, compare every output
    task automatic cycle();
        int exp_rd;
        exp_rd = ARESET ? 0 : sel_val(int'(rd_sel));
        model_step();
        @(posedge ACLK);
        #1;
        cyc++;
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("rd_outstanding", 32'(rd_outstanding), 32'(m_rd));
        check("wr_outstanding", 32'(wr_outstanding), 32'(m_wo));
        check("resp_err", 32'(resp_err), 32'(m_resp));
        check("proto_err", 32'(proto_err), 32'(m_proto));
    endtask

    task automatic idle_inputs();
        mon_arvalid = 0; mon_arready = 0; mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
        mon_rresp = 0; mon_awvalid = 0; mon_awready = 0; mon_wvalid = 0; mon_wready = 0;
        mon_wlast = 0; mon_bvalid = 0; mon_bready = 0; mon_bresp = 0;
        clear = 0; enable = 1; ARESET = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); ARESET = 1; cycle(); ARESET = 0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        mon_arvalid = 1; mon_arready = 1; mon_araddr = a; cycle();
        mon_arvalid = 0; mon_arready = 0;
    endtask

    task automatic do_r(input logic [1:0] resp);
        mon_rvalid = 1; mon_rready = 1; mon_rlast = 1; mon_rresp = resp; cycle();
        mon_rvalid = 0; mon_rready = 0; mon_rlast = 0; mon_rresp = 0;
    endtask

    task automatic do_aw();
        mon_awvalid = 1; mon_awready = 1; cycle(); mon_awvalid = 0; mon_awready = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic read_sel(input string tag, input logic [2:0] s, input int exp);
        rd_sel = s; cycle();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        cyc = 0;
        model_zero();
        // reset state
        do_reset();
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_os", 32'(rd_outstanding), 32'd0);
        check("reset_flags", 32'({proto_err, resp_err}), 32'd0);

        // instruction vs data classification
        do_ar(32'h0); do_ar(32'h4); do_ar(32'h200);
        read_sel("t1_inst", 3'd0, 2);
        read_sel("t1_data", 3'd1, 1);
        read_sel("t1_sum", 3'd6, 3);

        // worst-case latency
        do_reset();
        do_ar(32'h300); idle(6); do_r(2'b00);
        do_ar(32'h300); idle(2); do_r(2'b00);
        read_sel("t2_maxlat", 3'd5, 7);
        check("t2_rd_os", 32'(rd_outstanding), 32'd0);

        // write burst with SLVERR
        do_reset();
        do_aw();
        for (int i = 0; i < 4; i++) begin
            mon_wvalid = 1; mon_wready = 1; mon_wlast = (i == 3); cycle();
        end
        mon_wvalid = 0; mon_wready = 0; mon_wlast = 0;
        mon_bvalid = 1; mon_bready = 1; mon_bresp = 2'b10; cycle();
        mon_bvalid = 0; mon_bready = 0; mon_bresp = 0;
        read_sel("t3_wr", 3'd2, 1);
        read_sel("t3_wbeat", 3'd3, 4);
        read_sel("t3_err", 3'd4, 1);
        check("t3_flags", 32'({proto_err, resp_err}), 32'b01);

        // too many outstanding, then completion with none outstanding
        do_reset();
        for (int i = 0; i < 4; i++) do_ar(32'h1000);
        check("t4_proto_at4", 32'(proto_err), 32'd0);
        do_ar(32'h1000);
        check("t4_proto_at5", 32'(proto_err), 32'd1);
        do_reset();
        do_r(2'b00);
        check("t4_orphan_proto", 32'(proto_err), 32'd1);
        check("t4_orphan_os", 32'(rd_outstanding), 32'd0);

        // simultaneous AR and read completion
        do_reset();
        do_ar(32'h400);
        mon_arvalid = 1; mon_arready = 1; mon_araddr = 32'h400;
        mon_rvalid = 1; mon_rready = 1; mon_rlast = 1; cycle();
        idle_inputs();
        check("t5_rd_os", 32'(rd_outstanding), 32'd1);
        read_sel("t5_data", 3'd1, 2);

        // saturation, clear priority, enable freeze
        do_reset();
        for (int i = 0; i < 16; i++) do_aw();
        read_sel("t6_sat", 3'd2, 15);
        clear = 1; do_aw(); clear = 0;
        read_sel("t6_clear", 3'd2, 0);
        enable = 0; do_aw(); enable = 1;
        read_sel("t6_frozen", 3'd2, 0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            mon_arvalid = ($urandom_range(0, 9) < 4);
            mon_arready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: mon_araddr = 32'($urandom_range(0, 'hFF));
                1: mon_araddr = ($urandom_range(0, 1) == 0) ? 32'hFF : 32'h100;
                2: mon_araddr = 32'($urandom_range('h100, 'h3FF));
                default: mon_araddr = $urandom;
            endcase
            mon_rvalid  = ($urandom_range(0, 9) < 7);
            mon_rready  = ($urandom_range(0, 9) < 8);
            mon_rlast   = ($urandom_range(0, 1) == 0);
            mon_rresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mon_awvalid = ($urandom_range(0, 9) < 4);
            mon_awready = ($urandom_range(0, 3) != 0);
            mon_wvalid  = ($urandom_range(0, 9) < 7);
            mon_wready  = ($urandom_range(0, 9) < 8);
            mon_wlast   = ($urandom_range(0, 1) == 0);
            mon_bvalid  = ($urandom_range(0, 9) < 5);
            mon_bready  = ($urandom_range(0, 9) < 6);
            mon_bresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            clear       = ($urandom_range(0, 59) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            ARESET      = ($urandom_range(0, 399) == 0);
            rd_sel      = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
